// File: rtl/nmr_bstrm_sram_arb.sv
// rtl/nmr_bstrm_sram_arb.sv - command SRAM port arbiter: round-robin readers, priority host writer
//
// Shares one SRAM port between NUM_REQ read-only bitstream controllers and one
// host write port. Host writes win over readers; readers are served round-robin.
// Reads return after a fixed RD_LAT, tracked by a tag pipe that steers RD_VLD.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req, req_addr      per-requester read request (held until gnt) and address slices
//   gnt                one-cycle pulse: requester i issued to SRAM this cycle
//   rd_vld, rd_dat     one-hot read return strobe, broadcast read data
//   host_wr_req/addr/dat, host_wr_gnt   host write request and issue pulse
//   sram_addr, sram_cs, sram_clken, sram_wr, sram_wr_dat, sram_byteen, sram_rd_dat   RAM side
//   busy               any read in flight
module nmr_bstrm_sram_arb #(
    parameter int NUM_REQ           = 2,
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16,
    parameter int RD_LAT            = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rd_vld,
    output logic [SRAM_DAT_WIDTH-1:0]            rd_dat,
    input  logic                                 host_wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]           host_wr_addr,
    input  logic [SRAM_DAT_WIDTH-1:0]            host_wr_dat,
    output logic                                 host_wr_gnt,
    output logic [SRAM_ADDR_WIDTH-1:0]           sram_addr,
    output logic                                 sram_cs,
    output logic                                 sram_clken,
    output logic                                 sram_wr,
    input  logic [SRAM_DAT_WIDTH-1:0]            sram_rd_dat,
    output logic [SRAM_DAT_WIDTH-1:0]            sram_wr_dat,
    output logic [SRAM_BYTEEN_WIDTH-1:0]         sram_byteen,
    output logic                                 busy
);

    localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]           ptr;
    logic [PTR_W-1:0]           scan_idx;
    logic [PTR_W-1:0]           win_id;
    logic [NUM_REQ-1:0]         elig;
    logic [NUM_REQ-1:0]         win_oh;
    logic                       win_vld;
    logic                       host_win;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr;

    logic [RD_LAT-1:0]          tag_vld;
    logic [NUM_REQ-1:0]         tag_id [RD_LAT];

    // Registered grants mask the cycle in which a requester still holds its
    // request after being served, so nobody is issued twice for one request.
    always_comb begin
        host_win = host_wr_req && !host_wr_gnt;
        elig     = req & ~gnt;
        win_vld  = 1'b0;
        win_id   = ptr;
        win_oh   = '0;
        scan_idx = ptr;
        // Scan ptr+1, ptr+2, ... wrapping; first eligible requester wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == PTR_LAST) ? '0 : scan_idx + PTR_W'(1);
            if (!win_vld && elig[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_vld && (win_id == PTR_W'(i))) begin
                win_oh[i] = 1'b1;
            end
        end
        rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                rd_addr = rd_addr | req_addr[i*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= PTR_LAST;
            gnt         <= '0;
            host_wr_gnt <= 1'b0;
            sram_cs     <= 1'b0;
            sram_wr     <= 1'b0;
            sram_addr   <= '0;
            sram_wr_dat <= '0;
            tag_vld     <= '0;
            rd_vld      <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            gnt         <= '0;
            host_wr_gnt <= 1'b0;
            sram_cs     <= 1'b0;
            sram_wr     <= 1'b0;
            if (host_win) begin
                host_wr_gnt <= 1'b1;
                sram_cs     <= 1'b1;
                sram_wr     <= 1'b1;
                sram_addr   <= host_wr_addr;
                sram_wr_dat <= host_wr_dat;
            end else if (win_vld) begin
                gnt       <= win_oh;
                sram_cs   <= 1'b1;
                sram_addr <= rd_addr;
                ptr       <= win_id;
            end

            // Stage 0 lines up with the sram_cs cycle; writes enter an empty tag.
            tag_vld[0] <= !host_win && win_vld;
            tag_id[0]  <= host_win ? '0 : win_oh;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            rd_vld <= tag_vld[RD_LAT-1] ? tag_id[RD_LAT-1] : '0;
        end
    end

    // RAM output is passed straight through; gated so it reads zero when idle.
    assign rd_dat      = (|rd_vld) ? sram_rd_dat : '0;
    assign busy        = |tag_vld;
    assign sram_clken  = 1'b1;
    assign sram_byteen = '1;

endmodule
